// File: rtl/mini_cpu_pkg.sv
// Shared types and constants for the mini-cpu multi-cycle sequencer.
// ctrl_for() gives the registered control word that belongs to each state.
package mini_cpu_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, RTYPE_WB, BRANCH, HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_DOUBLE = 3'b011;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;
  typedef enum logic [1:0] {
    SRC_B_RS2, SRC_B_FOUR, SRC_B_IMM_MEM, SRC_B_IMM_BRANCH
  } alu_src_b_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    alu_src_b_t alu_src_b;
    logic       alu_src_a;
    alu_op_t    alu_op;
    logic       illegal;
  } ctrl_t;

  // Everything not named for a state stays 0, so unused selects read as 0.
  function automatic ctrl_t ctrl_for(input state_t s, input alu_op_t exec_op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRC_B_FOUR;
      end
      DECODE:   c.alu_src_b = SRC_B_IMM_BRANCH;
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM_MEM;
      end
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = exec_op;
      end
      RTYPE_WB: c.reg_write = 1'b1;
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 1'b1;
      end
      HALT:    c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// R-type funct decode: {funct7_5, funct3} -> ALU operation plus a legality flag.
module alu_op_decode
  import mini_cpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_t    alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case ({funct7_5, funct3})
      4'b0000: alu_op = ALU_ADD;
      4'b1000: alu_op = ALU_SUB;
      4'b0111: alu_op = ALU_AND;
      4'b0110: alu_op = ALU_OR;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the mini-cpu (ld, sd, beq, add/sub/and/or).
// Optional MC_PERF_CNT_EN adds the xlen parameter and the instret retire counter.
module multicycle_control
`ifdef MC_PERF_CNT_EN
  #(parameter int xlen = 64)
`endif
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic       alu_src_a,
  output logic [1:0] alu_op,
  output logic       illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [xlen-1:0] instret
`endif
);
  import mini_cpu_pkg::*;

  state_t  state_reg, state_next;
  ctrl_t   ctrl_reg;
  alu_op_t exec_op;
  logic    exec_legal;
  logic    fetch_done;

  alu_op_decode u_alu_op_decode (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (exec_op),
    .legal    (exec_legal)
  );

  // The first cycle after reset has mem_req low, so a fetch only completes once requested.
  assign fetch_done = (state_reg == FETCH) && ctrl_reg.mem_req && mem_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:    if (fetch_done) state_next = DECODE;
      DECODE: begin
        if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == F3_DOUBLE)
          state_next = MEM_ADDR;
        else if (opcode == OP_RTYPE && exec_legal)
          state_next = EXEC;
        else if (opcode == OP_BRANCH && funct3 == F3_BEQ)
          state_next = BRANCH;
        else
          state_next = HALT;
      end
      MEM_ADDR: state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_next = MEM_WB;
      MEM_WB:   state_next = FETCH;
      MEM_WR:   if (mem_ready) state_next = FETCH;
      EXEC:     state_next = RTYPE_WB;
      RTYPE_WB: state_next = FETCH;
      BRANCH:   state_next = FETCH;
      HALT:     state_next = HALT;
      default:  state_next = HALT;
    endcase
  end

  // Control word is computed for the state being entered, so outputs are pure flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= FETCH;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_for(state_next, exec_op);
    end
  end

  assign mem_req    = ctrl_reg.mem_req;
  assign mem_we     = ctrl_reg.mem_we;
  assign iord       = ctrl_reg.iord;
  assign pc_src     = ctrl_reg.pc_src;
  assign reg_write  = ctrl_reg.reg_write;
  assign mem_to_reg = ctrl_reg.mem_to_reg;
  assign alu_src_b  = ctrl_reg.alu_src_b;
  assign alu_src_a  = ctrl_reg.alu_src_a;
  assign alu_op     = ctrl_reg.alu_op;
  assign illegal    = ctrl_reg.illegal;

  // Write strobes must land in the completing cycle, hence decoded from live inputs.
  assign ir_write = fetch_done;
  assign pc_write = fetch_done || ((state_reg == BRANCH) && zero);

`ifdef MC_PERF_CNT_EN
  logic            retire;
  logic [xlen-1:0] instret_reg;

  assign retire = (state_reg == MEM_WB) || (state_reg == RTYPE_WB) ||
                  (state_reg == BRANCH) || ((state_reg == MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      instret_reg <= '0;
    else if (retire)
      instret_reg <= instret_reg + {{(xlen-1){1'b0}}, 1'b1};
  end

  assign instret = instret_reg;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction cycle scripts built from the
// instruction class, randomized waits/operands, optional instret checks with MC_PERF_CNT_EN.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic       reg_write, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op;
`ifdef MC_PERF_CNT_EN
  logic [63:0] instret;
`endif

  multicycle_control dut (
    .clk        (clk),
    .rstn       (rstn),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .alu_src_a  (alu_src_a),
    .alu_op     (alu_op),
    .illegal    (illegal)
`ifdef MC_PERF_CNT_EN
    ,
    .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg;
    logic [1:0] src_b;
    logic       src_a;
    logic [1:0] op;
    logic       illegal;
  } vec_t;

  // ready/zr: 0 or 1 = forced value, 2 = random (don't care for the DUT)
  typedef struct packed {
    vec_t        exp;
    logic [1:0]  ready;
    logic [1:0]  zr;
    logic        fv;
    logic        retire;
    logic [31:0] word;
  } ent_t;

  ent_t        q[$];
  string       tq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_instret = '0;
  bit          pend = 1'b0;

  task automatic check_vec(input vec_t e, input string tag);
    vec_t o;
    o = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
         alu_src_b, alu_src_a, alu_op, illegal};
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
`ifdef MC_PERF_CNT_EN
    n_vec++;
    assert (instret === exp_instret) else begin
      n_err++;
      $error("FAIL %s_instret: observed %0d expected %0d", tag, instret, exp_instret);
    end
`endif
  endtask

  task automatic push(input vec_t e, input logic [1:0] rdy, input logic [1:0] zr,
                      input logic fv, input logic ret, input logic [31:0] w, input string tag);
    ent_t x;
    x.exp = e; x.ready = rdy; x.zr = zr; x.fv = fv; x.retire = ret; x.word = w;
    q.push_back(x);
    tq.push_back(tag);
  endtask

  // Expected cycle script of one instruction, derived from its class.
  task automatic push_instr(input logic [31:0] w, input logic zv, input int fwait,
                            input int mwait, input int halt_n);
    vec_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] ff;
    int         rop;
    op = w[6:0]; f3 = w[14:12]; ff = {w[30], w[14:12]};
    rop = -1;
    if (ff == 4'b0000) rop = 0;
    if (ff == 4'b1000) rop = 1;
    if (ff == 4'b0111) rop = 2;
    if (ff == 4'b0110) rop = 3;
    for (int i = 0; i < fwait; i++) begin
      e = '0; e.mem_req = 1; e.src_b = 2'd1;
      push(e, 2'd0, 2'd2, 1'b0, 1'b0, w, "fetch_wait");
    end
    e = '0; e.mem_req = 1; e.src_b = 2'd1; e.ir_write = 1; e.pc_write = 1;
    push(e, 2'd1, 2'd2, 1'b0, 1'b0, w, "fetch_done");
    e = '0; e.src_b = 2'd3;
    push(e, 2'd2, 2'd2, 1'b1, 1'b0, w, "decode");
    if ((op == 7'h03 || op == 7'h23) && f3 == 3'b011) begin
      e = '0; e.src_a = 1; e.src_b = 2'd2;
      push(e, 2'd2, 2'd2, 1'b1, 1'b0, w, "mem_addr");
      e = '0; e.mem_req = 1; e.iord = 1; e.mem_we = (op == 7'h23);
      for (int i = 0; i < mwait; i++) push(e, 2'd0, 2'd2, 1'b1, 1'b0, w, "mem_wait");
      push(e, 2'd1, 2'd2, 1'b1, (op == 7'h23), w, "mem_done");
      if (op == 7'h03) begin
        e = '0; e.reg_write = 1; e.mem_to_reg = 1;
        push(e, 2'd2, 2'd2, 1'b1, 1'b1, w, "ld_wb");
      end
    end else if (op == 7'h33 && rop >= 0) begin
      e = '0; e.src_a = 1; e.op = 2'(rop);
      push(e, 2'd2, 2'd2, 1'b1, 1'b0, w, "exec");
      e = '0; e.reg_write = 1;
      push(e, 2'd2, 2'd2, 1'b1, 1'b1, w, "rtype_wb");
    end else if (op == 7'h63 && f3 == 3'b000) begin
      e = '0; e.src_a = 1; e.op = 2'd1; e.pc_src = 1; e.pc_write = zv;
      push(e, 2'd2, {1'b0, zv}, 1'b1, 1'b1, w, "branch");
    end else begin
      e = '0; e.illegal = 1;
      for (int i = 0; i < halt_n; i++) push(e, 2'd2, 2'd2, 1'b1, 1'b0, w, "halt");
    end
  endtask

  task automatic run_queue();
    ent_t  x;
    string t;
    while (q.size() > 0) begin
      x = q.pop_front();
      t = tq.pop_front();
      @(posedge clk);
      if (pend) exp_instret = exp_instret + 64'd1;
      pend = x.retire;
      #1;
      mem_ready = (x.ready == 2'd2) ? 1'($urandom_range(1)) : x.ready[0];
      zero      = (x.zr == 2'd2) ? 1'($urandom_range(1)) : x.zr[0];
      if (x.fv) begin
        opcode = x.word[6:0]; funct3 = x.word[14:12]; funct7_5 = x.word[30];
      end else begin
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
      end
      @(negedge clk);
      check_vec(x.exp, t);
    end
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    mem_ready = 1'b0;
    #1;
    pend = 1'b0;
    exp_instret = '0;
    check_vec('0, "rst_assert");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_vec('0, "rst_release");
  endtask

  function automatic logic [31:0] rand_word(input int kind);
    logic [3:0] rsel[4];
    logic [3:0] s;
    rsel = '{4'b0000, 4'b1000, 4'b0111, 4'b0110};
    s = rsel[$urandom_range(3)];
    case (kind)
      0:       return {12'($urandom), 5'($urandom), 3'b011, 5'($urandom), 7'h03};
      1:       return {7'($urandom), 5'($urandom), 5'($urandom), 3'b011, 5'($urandom), 7'h23};
      2:       return {7'($urandom), 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h63};
      default: return {1'b0, s[3], 5'b0, 5'($urandom), 5'($urandom), s[2:0], 5'($urandom), 7'h33};
    endcase
  endfunction

  initial begin
    logic [31:0] bad[4];
    bad = '{32'h00002003, 32'h00001063, 32'h00001033, 32'h40007033};

    do_reset();
    // beq taken / not taken, ld with slow memory, sd, sub
    push_instr(32'h02208463, 1'b1, 0, 0, 0);
    push_instr(32'h02208463, 1'b0, 1, 0, 0);
    push_instr(32'h02213103, 1'b0, 0, 3, 0);
    push_instr(32'hec62ba23, 1'b0, 2, 1, 0);
    push_instr(32'h40208033, 1'b0, 0, 0, 0);
    run_queue();

    // reset while a fetch request is outstanding
    push_instr(32'h02208463, 1'b1, 0, 0, 0);
    push(vec_t'({1'b1, 7'b0, 2'd1, 1'b0, 2'd0, 1'b0}), 2'd0, 2'd2, 1'b0, 1'b0, '0, "fetch_wait");
    push(vec_t'({1'b1, 7'b0, 2'd1, 1'b0, 2'd0, 1'b0}), 2'd0, 2'd2, 1'b0, 1'b0, '0, "fetch_wait");
    run_queue();
    do_reset();

    for (int n = 0; n < 40; n++) begin
      push_instr(rand_word($urandom_range(3)), 1'($urandom), $urandom_range(3),
                 $urandom_range(3), 0);
      run_queue();
    end

    // retire sequence then illegal: counter must freeze, illegal sticky
    do_reset();
    push_instr(32'h02208463, 1'b1, 0, 0, 0);
    push_instr(32'h02213103, 1'b0, 0, 0, 0);
    push_instr(32'hec62ba23, 1'b0, 0, 0, 0);
    push_instr(32'h40208033, 1'b0, 0, 0, 0);
    push_instr(32'h0000707f, 1'b0, 0, 0, 6);
    run_queue();
    do_reset();

    for (int n = 0; n < 4; n++) begin
      push_instr(bad[n], 1'b0, $urandom_range(2), 0, 3);
      run_queue();
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
